// File: rtl/switch_alloc_pkg.sv
// Shared NoC definitions for the switch allocator: port indices, flit field
// positions and the XY route function.
package noc_pkg;

   localparam int NUM_PORTS = 5;
   localparam int PORT_N    = 0;
   localparam int PORT_S    = 1;
   localparam int PORT_E    = 2;
   localparam int PORT_W    = 3;
   localparam int PORT_L    = 4;

   localparam int COORD_W   = 2;
   localparam int DEST_X_HI = 15;
   localparam int DEST_X_LO = 14;
   localparam int DEST_Y_HI = 13;
   localparam int DEST_Y_LO = 12;

   typedef logic [COORD_W-1:0]   coord_t;
   typedef logic [NUM_PORTS-1:0] port_vec_t;

   // X is resolved before Y, so a flit never turns back the way it came.
   function automatic port_vec_t xy_route(coord_t dest_x, coord_t dest_y,
                                          coord_t my_x,   coord_t my_y);
      port_vec_t oh;
      oh = '0;
      if (dest_x > my_x)      oh[PORT_E] = 1'b1;
      else if (dest_x < my_x) oh[PORT_W] = 1'b1;
      else if (dest_y > my_y) oh[PORT_S] = 1'b1;
      else if (dest_y < my_y) oh[PORT_N] = 1'b1;
      else                    oh[PORT_L] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/switch_alloc_if.sv
// Buffer-head / output-register bundle between the switch allocator (master)
// and the input buffers plus downstream links (slave).
interface switch_alloc_if #(
   parameter int FLIT_W = 16
);
   logic [noc_pkg::NUM_PORTS-1:0][FLIT_W-1:0] head_i;
   logic [noc_pkg::NUM_PORTS-1:0]             empty_i;
   logic [noc_pkg::NUM_PORTS-1:0]             pop_req_o;
   logic [noc_pkg::NUM_PORTS-1:0][FLIT_W-1:0] flit_o;
   logic [noc_pkg::NUM_PORTS-1:0]             valid_o;
   logic [noc_pkg::NUM_PORTS-1:0]             ready_i;

   modport master (
      input  head_i, empty_i, ready_i,
      output pop_req_o, flit_o, valid_o
   );

   modport slave (
      output head_i, empty_i, ready_i,
      input  pop_req_o, flit_o, valid_o
   );
endinterface

// File: rtl/switch_alloc_rr_arb5.sv
// Five-way round-robin arbiter for one output port; the search starts at the
// pointer and the pointer moves past the winner only when a grant is issued.
module rr_arb5
   import noc_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  port_vec_t req,
   input  logic      en,
   output port_vec_t gnt
);

   logic [2:0] ptr;
   logic [2:0] ptr_nxt;
   logic [2:0] idx;
   logic       found;

   // NOTE: every signal driven here gets a default first, so no path infers a latch.
   always_comb begin
      gnt     = '0;
      ptr_nxt = ptr;
      found   = 1'b0;
      idx     = ptr;
      for (int k = 0; k < NUM_PORTS; k++) begin
         if (en && !found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
            ptr_nxt  = (idx == 3'd4) ? 3'd0 : idx + 3'd1;
         end
         idx = (idx == 3'd4) ? 3'd0 : idx + 3'd1;
      end
   end

   // NOTE: registered state always uses non-blocking assignments.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) ptr <= '0;
      else      ptr <= ptr_nxt;
   end

endmodule

// File: rtl/switch_alloc.sv
// Router switch allocator: XY-routes each buffer head, arbitrates per output and
// registers winners. Define SWITCH_ALLOC_STATS_EN to add the flit_cnt_o counter.
module switch_alloc
   import noc_pkg::*;
#(
   parameter int MY_X   = 0,
   parameter int MY_Y   = 0,
   parameter int FLIT_W = 16
) (
   input  logic           clk,
   input  logic           rst,
   switch_alloc_if.master bus
`ifdef SWITCH_ALLOC_STATS_EN
   ,
   output logic [15:0]    flit_cnt_o
`endif
);

   localparam coord_t MY_XC = coord_t'(MY_X);
   localparam coord_t MY_YC = coord_t'(MY_Y);

   port_vec_t                          route_oh [NUM_PORTS];
   port_vec_t                          req      [NUM_PORTS];
   port_vec_t                          gnt      [NUM_PORTS];
   logic [FLIT_W-1:0]                  sel_flit [NUM_PORTS];
   port_vec_t                          free_out;
   port_vec_t                          won;
   port_vec_t                          pop;
   port_vec_t                          valid_q;
   logic [NUM_PORTS-1:0][FLIT_W-1:0]   flit_q;

   // Requests are suppressed during reset so no buffer is popped while rst=0.
   always_comb begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         route_oh[i] = '0;
         if (rst && !bus.empty_i[i])
            route_oh[i] = xy_route(bus.head_i[i][DEST_X_HI:DEST_X_LO],
                                   bus.head_i[i][DEST_Y_HI:DEST_Y_LO], MY_XC, MY_YC);
      end
      for (int p = 0; p < NUM_PORTS; p++)
         for (int i = 0; i < NUM_PORTS; i++)
            req[p][i] = route_oh[i][p];
   end

   assign free_out = ~valid_q | bus.ready_i;

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_arb
      rr_arb5 u_arb (
         .clk (clk),
         .rst (rst),
         .req (req[p]),
         .en  (free_out[p]),
         .gnt (gnt[p])
      );
   end

   always_comb begin
      pop = '0;
      won = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         sel_flit[p] = '0;
         won[p]      = |gnt[p];
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (gnt[p][i]) begin
               sel_flit[p] = bus.head_i[i];
               pop[i]      = 1'b1;
            end
         end
      end
   end

   // A grant reloads the register even when the old flit leaves this cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= '0;
         flit_q  <= '0;
      end else begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (won[p]) begin
               flit_q[p]  <= sel_flit[p];
               valid_q[p] <= 1'b1;
            end else if (bus.ready_i[p]) begin
               valid_q[p] <= 1'b0;
            end
         end
      end
   end

   assign bus.pop_req_o = pop;
   assign bus.flit_o    = flit_q;
   assign bus.valid_o   = valid_q;

`ifdef SWITCH_ALLOC_STATS_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) flit_cnt_o <= '0;
      else      flit_cnt_o <= flit_cnt_o + 16'($countones(valid_q & bus.ready_i));
   end
`endif

endmodule

// File: doc/switch_alloc.md
Name: switch_alloc

Overview:
- Downstream consumer of the five router input buffers (N, S, E, W, Local).
- Each cycle it examines every non-empty buffer head and computes the XY route for that flit.
- It then arbitrates round-robin per output port, pops the winning heads and registers them into five output flit registers.
- Each output register has a valid/ready handshake toward the neighbouring router or the local core.

Parameters:
- MY_X, 0, router column coordinate (0..3).
- MY_Y, 0, router row coordinate (0..3).
- FLIT_W, 16, flit width in bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- head_i  in  5*FLIT_W  buffer head flits; slice p = port p (N=0, S=1, E=2, W=3, L=4).
- empty_i  in  5  buffer p empty; head_i[p] is valid only when empty_i[p]=0.
- pop_req_o  out  5  pops buffer p at the next clock edge (one-cycle pulse per flit).
- flit_o  out  5*FLIT_W  output register flits, indexed by output port.
- valid_o  out  5  output p holds a flit.
- ready_i  in  5  downstream accepts output p this cycle.

Behaviour:
- Flit format:
  - [15:14] dest_x
  - [13:12] dest_y
  - [11:0] payload, passed through untouched.
- Route, combinational, per input with empty_i=0:
  - dest_x>MY_X → E
  - dest_x<MY_X → W
  - otherwise dest_y>MY_Y → S
  - dest_y<MY_Y → N
  - otherwise → L
  - An input requests exactly one output per cycle, so at most one grant per input.
- Output p is free this cycle when valid_o[p]=0 or ready_i[p]=1.
  - Arbitration for output p happens only when it is free.
  - A held output with ready_i=0 grants nothing, and its pointer is unchanged.
- Arbiter: 5-way round robin per output.
  - Search starts at ptr[p].
  - After a grant to input i, ptr[p] ← (i+1) mod 5.
  - Pointers reset to 0 (N highest priority after reset).
- Grant to input i for output p, in the same cycle:
  - pop_req_o[i]=1 (combinational from grant).
  - At the edge: flit_o[p] ← head_i[i] and valid_o[p] ← 1.
- Latency: a flit visible at a buffer head at cycle t with a free, uncontested output appears on flit_o/valid_o at cycle t+1.
- Downstream handshake:
  - A transfer occurs when valid_o[p] & ready_i[p].
  - If a transfer occurs and there is no new grant: valid_o[p] ← 0.
  - If a transfer and a grant happen in the same cycle: the register loads the new flit with no bubble (full throughput, 1 flit/cycle/output).
- While valid_o[p]=1 and ready_i[p]=0, flit_o[p] is held stable.
- U-turns are not checked; XY routing never produces them.
- Reset, asserted any time including mid-transfer:
  - valid_o=0, flit_o=0, pop_req_o=0, pointers=0.
  - Flits in output registers are discarded.
  - Buffers are not popped while rst=0.
- pop_req_o is never asserted for an input whose empty_i=1.

Optional Feature:
- SWITCH_ALLOC_STATS_EN defined:
  - Adds output port flit_cnt_o [15:0].
  - The counter increments by popcount(valid_o & ready_i) each cycle (0..5) and wraps modulo 2^16.
  - It resets to 0.
- Not defined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- noc_pkg holds:
  - port index constants PORT_N..PORT_L and NUM_PORTS=5
  - flit field positions DEST_X_HI/LO and DEST_Y_HI/LO
  - COORD_W=2
  - the route-function used by the route logic
- Sub-module rr_arb5: 5-bit request, free/enable, one-hot grant output, internal pointer. Instantiated five times, once per output.

Test Plan:
- Single flit, MY=(1,1): N head 0xC123 (dest 3,0).
  - pop_req_o=00001.
  - Next cycle flit_o[E]=0xC123, valid_o[E]=1, other valid_o=0.
- Local delivery: W head with dest (1,1).
  - Output L is valid after 1 cycle.
  - Payload is unchanged.
- Contention: N, S, L all route to E every cycle, ready_i[E]=1.
  - Grants rotate N, S, L, N…
  - One pop per cycle, valid_o[E] continuously 1.
- Backpressure: ready_i[E]=0 for 4 cycles while E is held and two inputs request E.
  - No pops and flit_o[E] stable.
  - When ready rises, the next flit loads in the same cycle with no bubble.
- Parallel: N→S, S→N, E→W, W→E, L→L simultaneously.
  - All five popped in the same cycle.
  - All valid_o=1 next cycle.
- Async reset mid-stream: assert rst=0 between clock edges.
  - valid_o and pop_req_o drop immediately.
  - After release, the first grant goes to the lowest-index requester.
  - With SWITCH_ALLOC_STATS_EN, flit_cnt_o=0.
